// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate generator with PC-relative target behind a two-entry skid buffer
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [31:0]     inst_i,
  input  logic [2:0]      imm_sel_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] imm_data_o,
  output logic [XLEN-1:0] tgt_addr_o,
  output logic            illegal_o
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;
  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] tgt;
    logic            ill;
  } beat_t;
  state_e          state_q, state_d;
  beat_t           m_q, m_d, s_q, s_d, new_c;
  logic [XLEN-1:0] imm_c;
  logic            acc, dep;
  logic            unused_opcode;
  assign unused_opcode = ^inst_i[6:0];
  // Extract and extend the immediate for the selected format
  always_comb begin
    imm_c = '0;
    case (imm_sel_i)
      3'b000:  imm_c = XLEN'($signed(inst_i[31:20]));
      3'b001:  imm_c = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
      3'b010:  imm_c = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
      3'b011:  imm_c = XLEN'($signed({inst_i[31:12], 12'b0}));
      3'b100:  imm_c = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
      3'b101:  imm_c = XLEN'(inst_i[19:15]);
      3'b110:  imm_c = (XLEN == 64) ? XLEN'(inst_i[25:20]) : XLEN'(inst_i[24:20]);
      default: imm_c = '0;
    endcase
  end
  assign new_c   = {imm_c, pc_i + imm_c, &imm_sel_i};
  assign ready_o = state_q != TWO;
  assign valid_o = state_q != EMPTY;
  assign acc     = valid_i & ready_o;
  assign dep     = valid_o & ready_i;
  // Skid-buffer sequencing: M feeds the output, S catches the beat accepted while M is stalled
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    case (state_q)
      EMPTY: if (acc) begin
        state_d = ONE;
        m_d     = new_c;
      end
      ONE: if (acc && dep) m_d = new_c;
      else if (acc) begin
        state_d = TWO;
        s_d     = new_c;
      end else if (dep) state_d = EMPTY;
      TWO: if (dep) begin
        state_d = ONE;
        m_d     = s_q;
      end
      default: state_d = EMPTY;
    endcase
    if (flush_i) state_d = EMPTY;
  end
  // State and data registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end
  assign imm_data_o = m_q.imm;
  assign tgt_addr_o = m_q.tgt;
  assign illegal_o  = m_q.ill;
endmodule
